// File: rtl/usr_pkg.sv
// Shared mode encodings and widths for universal_shift_reg.
package usr_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_SHL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_CLR  = 3'b110
  } mode_e;

endpackage

// File: rtl/dff_cell.sv
// One-bit rising-edge flip-flop with async active-low reset to RST_VAL and complement output.
module dff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic qn
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

  assign qn = ~q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/clear per clock, true and complement outputs.
// Rotate modes are built only when USR_ROTATE_EN is defined; otherwise 100/101 hold.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int             WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              EN,
  input  logic [MODE_W-1:0] MODE,
  input  logic [WIDTH-1:0]  D,
  input  logic              SI_MSB,
  input  logic              SI_LSB,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  Qn,
  output logic              SO_MSB,
  output logic              SO_LSB
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // Neighbour indices wrap at the ends; with WIDTH=1 both point at bit 0, so rotate holds.
    localparam int UP = (i == WIDTH - 1) ? 0 : i + 1;
    localparam int DN = (i == 0) ? WIDTH - 1 : i - 1;

    logic shr_src;
    logic shl_src;
    logic nxt;

    assign shr_src = (i == WIDTH - 1) ? SI_MSB : Q[UP];
    assign shl_src = (i == 0) ? SI_LSB : Q[DN];

    always_comb begin
      nxt = Q[i];
      if (EN) begin
        case (MODE)
          MODE_HOLD: nxt = Q[i];
          MODE_LOAD: nxt = D[i];
          MODE_SHR:  nxt = shr_src;
          MODE_SHL:  nxt = shl_src;
`ifdef USR_ROTATE_EN
          MODE_ROR:  nxt = Q[UP];
          MODE_ROL:  nxt = Q[DN];
`else
          MODE_ROR,
          MODE_ROL:  nxt = Q[i];
`endif
          MODE_CLR:  nxt = 1'b0;
          3'b111:    nxt = Q[i];
          default:   nxt = 1'bx;
        endcase
      end
    end

    dff_cell #(
      .RST_VAL (RESET_VAL[i])
    ) u_cell (
      .clk   (CLK),
      .rst_n (RSTn),
      .d     (nxt),
      .q     (Q[i]),
      .qn    (Qn[i])
    );
  end

  assign SO_MSB = Q[WIDTH-1];
  assign SO_LSB = Q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg: an 8-bit instance plus a 1-bit instance with RESET_VAL=1.
module tb_universal_shift_reg;
  import usr_pkg::*;

  logic       CLK;
  logic       RSTn;
  logic       EN;
  logic [2:0] MODE;
  logic [7:0] D;
  logic       SI_MSB;
  logic       SI_LSB;
  logic [7:0] Q;
  logic [7:0] Qn;
  logic       SO_MSB;
  logic       SO_LSB;

  logic       w1_rst_n;
  logic       w1_en;
  logic [2:0] w1_mode;
  logic [0:0] w1_d;
  logic       w1_si_msb;
  logic       w1_si_lsb;
  logic [0:0] w1_q;
  logic [0:0] w1_qn;
  logic       w1_so_msb;
  logic       w1_so_lsb;

  int n_cmp = 0;
  int n_err = 0;

`ifdef USR_ROTATE_EN
  localparam logic [7:0] EXP_ROL1 = 8'h03;
  localparam logic [7:0] EXP_ROR1 = 8'h81;
  localparam logic [7:0] EXP_ROR2 = 8'hC0;
`else
  localparam logic [7:0] EXP_ROL1 = 8'h81;
  localparam logic [7:0] EXP_ROR1 = 8'h81;
  localparam logic [7:0] EXP_ROR2 = 8'h81;
`endif

  universal_shift_reg #(
    .WIDTH     (8),
    .RESET_VAL (8'h00)
  ) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .EN     (EN),
    .MODE   (MODE),
    .D      (D),
    .SI_MSB (SI_MSB),
    .SI_LSB (SI_LSB),
    .Q      (Q),
    .Qn     (Qn),
    .SO_MSB (SO_MSB),
    .SO_LSB (SO_LSB)
  );

  universal_shift_reg #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) dut_w1 (
    .CLK    (CLK),
    .RSTn   (w1_rst_n),
    .EN     (w1_en),
    .MODE   (w1_mode),
    .D      (w1_d),
    .SI_MSB (w1_si_msb),
    .SI_LSB (w1_si_lsb),
    .Q      (w1_q),
    .Qn     (w1_qn),
    .SO_MSB (w1_so_msb),
    .SO_LSB (w1_so_lsb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, need finished");
    $fatal(1);
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; EN = 1'b0; MODE = MODE_HOLD; D = '0; SI_MSB = 1'b0; SI_LSB = 1'b0;
    #1;
    n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h need 00", Q); end
    n_cmp++; if (Qn !== 8'hFF) begin n_err++; $display("FAIL reset_qn: got %h need FF", Qn); end
    n_cmp++; if ({SO_MSB, SO_LSB} !== 2'b00) begin n_err++; $display("FAIL reset_so: got %b need 00", {SO_MSB, SO_LSB}); end
    tick();
    RSTn = 1'b1;
    EN = 1'b1; MODE = MODE_LOAD; D = 8'hA5;
    tick();
    n_cmp++; if (Q !== 8'hA5) begin n_err++; $display("FAIL load_a5: got %h need A5", Q); end
    #2 RSTn = 1'b0;
    #1;
    n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL async_reset_q: got %h need 00", Q); end
    n_cmp++; if (Qn !== 8'hFF) begin n_err++; $display("FAIL async_reset_qn: got %h need FF", Qn); end
    tick();
    n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL reset_blocks_load: got %h need 00", Q); end
    RSTn = 1'b1;
    tick();
    n_cmp++; if (Q !== 8'hA5) begin n_err++; $display("FAIL first_edge_after_reset: got %h need A5", Q); end
  endtask

  task automatic test_enable_hold();
    EN = 1'b1; MODE = MODE_LOAD; D = 8'h3C;
    tick();
    n_cmp++; if (Q !== 8'h3C) begin n_err++; $display("FAIL load_3c: got %h need 3C", Q); end
    EN = 1'b0; D = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (Q !== 8'h3C) begin n_err++; $display("FAIL en0_hold_%0d: got %h need 3C", i, Q); end
    end
    n_cmp++; if (Qn !== 8'hC3) begin n_err++; $display("FAIL en0_qn: got %h need C3", Qn); end
  endtask

  task automatic test_shift();
    EN = 1'b1; MODE = MODE_LOAD; D = 8'h81;
    tick();
    MODE = MODE_SHR; SI_MSB = 1'b0;
    #1;
    n_cmp++; if ({SO_MSB, SO_LSB} !== 2'b11) begin n_err++; $display("FAIL so_pre_shr: got %b need 11", {SO_MSB, SO_LSB}); end
    tick();
    n_cmp++; if (Q !== 8'h40) begin n_err++; $display("FAIL shr1: got %h need 40", Q); end
    n_cmp++; if (SO_LSB !== 1'b0) begin n_err++; $display("FAIL so_lsb_after_shr: got %b need 0", SO_LSB); end
    tick();
    n_cmp++; if (Q !== 8'h20) begin n_err++; $display("FAIL shr2: got %h need 20", Q); end
    SI_MSB = 1'b1;
    tick();
    n_cmp++; if (Q !== 8'h90) begin n_err++; $display("FAIL shr_si1: got %h need 90", Q); end
    MODE = MODE_SHL; SI_LSB = 1'b1;
    tick();
    n_cmp++; if (Q !== 8'h21) begin n_err++; $display("FAIL shl_si1: got %h need 21", Q); end
    SI_LSB = 1'b0;
    tick();
    n_cmp++; if (Q !== 8'h42) begin n_err++; $display("FAIL shl_si0: got %h need 42", Q); end
    SI_MSB = 1'b0;
  endtask

  task automatic test_rotate();
    EN = 1'b1; MODE = MODE_LOAD; D = 8'h81;
    tick();
    MODE = MODE_ROL;
    tick();
    n_cmp++; if (Q !== EXP_ROL1) begin n_err++; $display("FAIL rol1: got %h need %h", Q, EXP_ROL1); end
    MODE = MODE_ROR;
    tick();
    n_cmp++; if (Q !== EXP_ROR1) begin n_err++; $display("FAIL ror1: got %h need %h", Q, EXP_ROR1); end
    tick();
    n_cmp++; if (Q !== EXP_ROR2) begin n_err++; $display("FAIL ror2: got %h need %h", Q, EXP_ROR2); end
    MODE = 3'b111; D = 8'hFF;
    tick();
    n_cmp++; if (Q !== EXP_ROR2) begin n_err++; $display("FAIL mode111_hold: got %h need %h", Q, EXP_ROR2); end
  endtask

  task automatic test_clear();
    EN = 1'b1; MODE = MODE_LOAD; D = 8'h5A;
    tick();
    MODE = MODE_CLR;
    tick();
    n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL clr_q: got %h need 00", Q); end
    n_cmp++; if (Qn !== 8'hFF) begin n_err++; $display("FAIL clr_qn: got %h need FF", Qn); end
    EN = 1'b0; MODE = MODE_HOLD;
  endtask

  task automatic test_width1();
    n_cmp++; if (w1_q !== 1'b1) begin n_err++; $display("FAIL w1_reset_q: got %b need 1", w1_q); end
    n_cmp++; if (w1_qn !== 1'b0) begin n_err++; $display("FAIL w1_reset_qn: got %b need 0", w1_qn); end
    w1_rst_n = 1'b1;
    w1_en = 1'b1; w1_mode = MODE_CLR;
    tick();
    n_cmp++; if (w1_q !== 1'b0) begin n_err++; $display("FAIL w1_clr: got %b need 0", w1_q); end
    w1_mode = MODE_SHL; w1_si_lsb = 1'b1; w1_si_msb = 1'b0;
    tick();
    n_cmp++; if ({w1_q, w1_qn} !== 2'b10) begin n_err++; $display("FAIL w1_shl: got q/qn %b need 10", {w1_q, w1_qn}); end
    n_cmp++; if ({w1_so_msb, w1_so_lsb} !== 2'b11) begin n_err++; $display("FAIL w1_so: got %b need 11", {w1_so_msb, w1_so_lsb}); end
    w1_mode = MODE_SHR;
    tick();
    n_cmp++; if (w1_q !== 1'b0) begin n_err++; $display("FAIL w1_shr: got %b need 0", w1_q); end
    w1_mode = MODE_ROR;
    tick();
    n_cmp++; if (w1_q !== 1'b0) begin n_err++; $display("FAIL w1_ror_hold: got %b need 0", w1_q); end
    w1_mode = MODE_LOAD; w1_d = 1'b1;
    tick();
    w1_mode = MODE_ROL;
    tick();
    n_cmp++; if (w1_q !== 1'b1) begin n_err++; $display("FAIL w1_rol_hold: got %b need 1", w1_q); end
    w1_en = 1'b0;
  endtask

  initial begin
    w1_rst_n = 1'b0; w1_en = 1'b0; w1_mode = MODE_HOLD; w1_d = '0;
    w1_si_msb = 1'b0; w1_si_lsb = 1'b0;
    test_reset();
    test_enable_hold();
    test_shift();
    test_rotate();
    test_clear();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
